// File: rtl/hello_world_vec.sv
// Multi-lane hello_world: per-lane increment or running accumulate under an
// ap_ctrl_hs handshake, with a result LATENCY cycles after acceptance.
module hello_world_vec #(
   parameter int WIDTH   = 32,
   parameter int LANES   = 4,
   parameter int INCR    = 1,
   parameter int LATENCY = 2
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic                   ap_start,
   input  logic                   mode,
   input  logic                   clr_acc,
   input  logic [LANES*WIDTH-1:0] a,
   output logic                   ap_ready,
   output logic                   ap_done,
   output logic                   ap_idle,
   output logic [LANES*WIDTH-1:0] b,
   output logic                   b_ap_vld
);

   localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [WIDTH-1:0] INCR_W   = WIDTH'(INCR);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [LANES*WIDTH-1:0]   a_q;
   logic                     mode_q;
   logic                     ready_q;
   logic                     done_q;
   logic                     finish;

   // The last BUSY cycle: the edge that ends it enters DONE and updates b/acc.
   assign finish = (state_q == S_BUSY) && (cnt_q == '0);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         mode_q  <= 1'b0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (ap_start) begin
                  a_q     <= a;
                  mode_q  <= mode;
                  cnt_q   <= CNT_LOAD;
                  ready_q <= 1'b1;
                  state_q <= S_BUSY;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [WIDTH-1:0] a_lane;
         logic [WIDTH-1:0] sum;
         logic [WIDTH-1:0] acc_q;
         logic [WIDTH-1:0] b_lane_q;

         assign a_lane = a_q[gi*WIDTH +: WIDTH];
         assign sum    = mode_q ? (acc_q + a_lane) : (a_lane + INCR_W);

         // Clear has priority over the accumulate write-back on the same edge.
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               acc_q    <= '0;
               b_lane_q <= '0;
            end else begin
               if (finish) begin
                  b_lane_q <= sum;
               end
               if (clr_acc) begin
                  acc_q <= '0;
               end else if (finish && mode_q) begin
                  acc_q <= sum;
               end
            end
         end

         assign b[gi*WIDTH +: WIDTH] = b_lane_q;
      end
   endgenerate

   assign ap_ready = ready_q;
   assign ap_done  = done_q;
   assign b_ap_vld = done_q;
   assign ap_idle  = (state_q == S_IDLE);

endmodule

// File: tb/tb_hello_world_vec.sv
// Bench for hello_world_vec: vector table of single ops, back-to-back streaming
// and reset-abort sequences; results are checked through a scoreboard queue.
module tb_hello_world_vec;

   localparam int WIDTH   = 32;
   localparam int LANES   = 4;
   localparam int LATENCY = 2;
   localparam int VW      = LANES * WIDTH;

   logic          ap_clk;
   logic          ap_rst_n;
   logic          ap_start;
   logic          mode;
   logic          clr_acc;
   logic [VW-1:0] a;
   logic          ap_ready;
   logic          ap_done;
   logic          ap_idle;
   logic [VW-1:0] b;
   logic          b_ap_vld;

   int total = 0;
   int bad   = 0;

   logic [VW-1:0] sb_q[$];

   typedef struct {
      logic          mode;
      logic          clr_before;
      logic          clr_at_done;
      logic [VW-1:0] a;
      logic [VW-1:0] exp_b;
   } vec_t;

   vec_t vecs[11];

   hello_world_vec #(
      .WIDTH  (WIDTH),
      .LANES  (LANES),
      .INCR   (1),
      .LATENCY(LATENCY)
   ) dut (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .ap_start(ap_start),
      .mode    (mode),
      .clr_acc (clr_acc),
      .a       (a),
      .ap_ready(ap_ready),
      .ap_done (ap_done),
      .ap_idle (ap_idle),
      .b       (b),
      .b_ap_vld(b_ap_vld)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Scoreboard: every ap_done must match the oldest outstanding expectation.
   always @(negedge ap_clk) begin
      if (ap_rst_n && ap_done) begin
         chk("b_ap_vld", VW'(b_ap_vld), VW'(1));
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got b=%h want no ap_done", b);
         end else begin
            chk("b_result", b, sb_q.pop_front());
         end
      end
   end

   function automatic logic [VW-1:0] plus1(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*WIDTH +: WIDTH] = v[l*WIDTH +: WIDTH] + 32'd1;
      return r;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge ap_clk);
      while (!ap_idle && n < 20) begin
         @(negedge ap_clk);
         n++;
      end
      if (!ap_idle) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got ap_idle=0 want 1 within 20 cycles");
      end
   endtask

   task automatic do_op(input vec_t v);
      wait_idle();
      a        = v.a;
      mode     = v.mode;
      clr_acc  = v.clr_before;
      ap_start = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_start = 1'b0;
      clr_acc  = 1'b0;
      sb_q.push_back(v.exp_b);
      for (int c = 1; c <= LATENCY; c++) begin
         @(negedge ap_clk);
         chk("ready_pulse", VW'(ap_ready), VW'(c == 1));
         chk("done_early", VW'(ap_done), VW'(0));
         if (c == LATENCY && v.clr_at_done) clr_acc = 1'b1;
         @(posedge ap_clk);
         #1;
         clr_acc = 1'b0;
      end
      @(negedge ap_clk);
      chk("done_timing", VW'(ap_done), VW'(1));
      @(negedge ap_clk);
      chk("idle_after", VW'(ap_idle), VW'(1));
      chk("b_hold", b, v.exp_b);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [VW-1:0] cur;
      int gap;
      int n;

      vecs[0]  = '{1'b0, 1'b0, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd5, 32'd4, 32'd3, 32'd2}};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, {32'h10, 32'h20, 32'h30, 32'hFFFFFFFF}, {32'h11, 32'h21, 32'h31, 32'h0}};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, {4{32'd5}}, {4{32'd5}}};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, {4{32'd5}}, {4{32'd10}}};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, {4{32'd5}}, {4{32'd15}}};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, {4{32'd5}}, {4{32'd5}}};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd6, 32'd7, 32'd8, 32'd9}};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, {32'hFFFFFFFF, 32'd0, 32'd0, 32'd1}, {32'hFFFFFFFF, 32'd0, 32'd0, 32'd1}};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, {4{32'd1}}, {32'd0, 32'd1, 32'd1, 32'd2}};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, {4{32'd7}}, {4{32'd8}}};
      vecs[10] = '{1'b1, 1'b0, 1'b0, {4{32'd0}}, {32'd0, 32'd1, 32'd1, 32'd2}};

      ap_rst_n = 1'b0;
      ap_start = 1'b0;
      mode     = 1'b0;
      clr_acc  = 1'b0;
      a        = '0;
      repeat (3) @(negedge ap_clk);
      chk("rst_b", b, '0);
      chk("rst_done", VW'(ap_done), VW'(0));
      chk("rst_ready", VW'(ap_ready), VW'(0));
      chk("rst_idle", VW'(ap_idle), VW'(1));
      chk("rst_vld", VW'(b_ap_vld), VW'(0));
      ap_rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i]);
         $display("vec %0d: mode=%0d a=%h exp=%h b=%h", i, vecs[i].mode, vecs[i].a, vecs[i].exp_b, b);
      end

      // Back-to-back: ap_start held high, a advanced after every ap_ready.
      wait_idle();
      cur      = {32'd40, 32'd30, 32'd20, 32'd10};
      a        = cur;
      mode     = 1'b0;
      ap_start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         gap = 0;
         n   = 0;
         do begin
            @(negedge ap_clk);
            gap++;
            n++;
            if (k > 0) chk("b2b_idle", VW'(ap_idle), VW'(0));
         end while (!ap_ready && n < 10);
         chk("b2b_ready_seen", VW'(ap_ready), VW'(1));
         if (k > 0) chk("b2b_gap", VW'(gap), VW'(LATENCY + 1));
         sb_q.push_back(plus1(cur));
         $display("b2b op %0d: a=%h exp=%h", k, cur, plus1(cur));
         cur = cur + {32'd1, 32'd1, 32'd1, 32'd1};
         a   = cur;
         if (k == 3) ap_start = 1'b0;
      end
      wait_idle();
      chk("b2b_drained", VW'(sb_q.size()), VW'(0));

      // Reset while BUSY must abort the op and clear b and the accumulators.
      a        = {4{32'd9}};
      mode     = 1'b1;
      ap_start = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_start = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      #1;
      chk("abort_idle", VW'(ap_idle), VW'(1));
      chk("abort_b", b, '0);
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (5) @(negedge ap_clk);
      chk("abort_b_after", b, '0);
      do_op('{1'b1, 1'b0, 1'b0, {4{32'd3}}, {4{32'd3}}});
      $display("post-reset op: exp=%h b=%h", {4{32'd3}}, b);

      chk("sb_empty", VW'(sb_q.size()), VW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
